// File: rtl/mode_controller.sv
// mode_controller: routes debounced buttons to the clock, setup, timer
// and stopwatch blocks and tracks the active mode, setup blink and alarm.
//
// Ports:
//   clock          system clock, all state changes on its rising edge
//   reset          synchronous active-high reset
//   btn_pulse[3:0] one-cycle button pulses: 0=MODE 1=B1 2=B2 3=B3
//   tick_2hz       one-cycle 2 Hz strobe (blink and inactivity timing)
//   timer_done     one-cycle pulse when the timer countdown reaches zero
//   rezhim[1:0]    active mode: 0=CLOCK 1=SETUP 2=TIMER 3=STOPWATCH
//   setup_inc/dec  one-cycle adjust pulses for the selected setup field
//   setup_field    selected setup field: 0=hours 1=minutes 2=seconds
//   timer_btn[2:0] timer pulses: 0=start/stop 1=reset 2=adjust
//   sw_start_stop  stopwatch start/stop pulse
//   sw_reset       stopwatch reset pulse
//   blank[5:0]     per-digit blank mask: 5:4=hh 3:2=mm 1:0=ss
//   alarm          timer alarm pending acknowledgement

module mode_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn_pulse,
    input  logic       tick_2hz,
    input  logic       timer_done,
    output logic [1:0] rezhim,
    output logic       setup_inc,
    output logic       setup_dec,
    output logic [1:0] setup_field,
    output logic [2:0] timer_btn,
    output logic       sw_start_stop,
    output logic       sw_reset,
    output logic [5:0] blank,
    output logic       alarm
);

    typedef enum logic [1:0] {
        M_CLOCK = 2'd0,
        M_SETUP = 2'd1,
        M_TIMER = 2'd2,
        M_SW    = 2'd3
    } mode_t;

    // 30 s of inactivity at 2 Hz; the timeout fires on the tick that
    // would take the counter to 60, so the counter never holds 60.
    localparam logic [5:0] IDLE_LAST = 6'd59;

    mode_t      mode_q;
    mode_t      mode_d;
    logic       phase_q;
    logic       phase_d;
    logic [5:0] idle_q;
    logic [5:0] idle_d;
    logic [1:0] field_d;
    logic       alarm_d;
    logic       inc_d;
    logic       dec_d;
    logic [2:0] tbtn_d;
    logic       sws_d;
    logic       swr_d;
    logic [5:0] blank_d;

    logic       mode_btn;
    logic       any_btn;
    logic [2:0] bx;

    assign mode_btn = btn_pulse[0];
    assign any_btn  = |btn_pulse;
    assign bx       = btn_pulse[3:1];
    assign rezhim   = mode_q;

    // Priority: timer_done, then alarm acknowledge, then MODE, then
    // per-mode routing of B1..B3 (including setup blink/timeout).
    always_comb begin
        mode_d  = mode_q;
        phase_d = phase_q;
        idle_d  = idle_q;
        field_d = setup_field;
        alarm_d = alarm;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        tbtn_d  = 3'b000;
        sws_d   = 1'b0;
        swr_d   = 1'b0;

        if (timer_done) begin
            alarm_d = 1'b1;
            mode_d  = M_TIMER;
        end else if (alarm && any_btn) begin
            // acknowledge swallows the whole pulse
            alarm_d = 1'b0;
        end else if (mode_btn) begin
            mode_d = mode_t'(mode_q + 2'd1);
            if (mode_d == M_SETUP) begin
                field_d = 2'd0;
                phase_d = 1'b0;
                idle_d  = 6'd0;
            end
        end else begin
            unique case (mode_q)
                M_SETUP: begin
                    if (|bx) begin
                        inc_d   = bx[0];
                        dec_d   = bx[1];
                        if (bx[2]) begin
                            if (setup_field == 2'd2) begin
                                field_d = 2'd0;
                            end else begin
                                field_d = setup_field + 2'd1;
                            end
                        end
                        // keep the edited field visible
                        phase_d = 1'b0;
                        idle_d  = 6'd0;
                    end else if (tick_2hz) begin
                        phase_d = ~phase_q;
                        if (idle_q >= IDLE_LAST) begin
                            mode_d = M_CLOCK;
                            idle_d = 6'd0;
                        end else begin
                            idle_d = idle_q + 6'd1;
                        end
                    end
                end
                M_TIMER: begin
                    tbtn_d = bx;
                end
                M_SW: begin
                    sws_d = bx[0];
                    swr_d = bx[1];
                end
                default: begin
                end
            endcase
        end

        if (any_btn) begin
            idle_d = 6'd0;
        end

        // blink and inactivity only live inside SETUP
        if (mode_d != M_SETUP) begin
            phase_d = 1'b0;
            idle_d  = 6'd0;
        end
    end

    // blank mask is built from next-state values so it is registered
    // together with the mode and field it describes
    always_comb begin
        blank_d = 6'b000000;
        if (mode_d == M_SETUP && phase_d) begin
            unique case (field_d)
                2'd0:    blank_d = 6'b110000;
                2'd1:    blank_d = 6'b001100;
                2'd2:    blank_d = 6'b000011;
                default: blank_d = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q        <= M_CLOCK;
            phase_q       <= 1'b0;
            idle_q        <= 6'd0;
            setup_field   <= 2'd0;
            alarm         <= 1'b0;
            setup_inc     <= 1'b0;
            setup_dec     <= 1'b0;
            timer_btn     <= 3'b000;
            sw_start_stop <= 1'b0;
            sw_reset      <= 1'b0;
            blank         <= 6'b000000;
        end else begin
            mode_q        <= mode_d;
            phase_q       <= phase_d;
            idle_q        <= idle_d;
            setup_field   <= field_d;
            alarm         <= alarm_d;
            setup_inc     <= inc_d;
            setup_dec     <= dec_d;
            timer_btn     <= tbtn_d;
            sw_start_stop <= sws_d;
            sw_reset      <= swr_d;
            blank         <= blank_d;
        end
    end

endmodule

// File: tb/tb_mode_controller.sv
// tb_mode_controller: directed scoreboard bench for mode_controller.
// Each step queues the expected output vector for the following edge.

module tb_mode_controller;

    typedef struct packed {
        logic [1:0] rz;
        logic       inc;
        logic       dec;
        logic [1:0] fld;
        logic [2:0] tb;
        logic       ss;
        logic       sr;
        logic [5:0] bl;
        logic       al;
    } out_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_pulse = 4'h0;
    logic       tick_2hz = 1'b0;
    logic       timer_done = 1'b0;
    logic [1:0] rezhim;
    logic       setup_inc;
    logic       setup_dec;
    logic [1:0] setup_field;
    logic [2:0] timer_btn;
    logic       sw_start_stop;
    logic       sw_reset;
    logic [5:0] blank;
    logic       alarm;

    mode_controller dut (
        .clock         (clock),
        .reset         (reset),
        .btn_pulse     (btn_pulse),
        .tick_2hz      (tick_2hz),
        .timer_done    (timer_done),
        .rezhim        (rezhim),
        .setup_inc     (setup_inc),
        .setup_dec     (setup_dec),
        .setup_field   (setup_field),
        .timer_btn     (timer_btn),
        .sw_start_stop (sw_start_stop),
        .sw_reset      (sw_reset),
        .blank         (blank),
        .alarm         (alarm)
    );

    always #5 clock = ~clock;

    out_t obs;
    assign obs = '{rz: rezhim, inc: setup_inc, dec: setup_dec,
                   fld: setup_field, tb: timer_btn, ss: sw_start_stop,
                   sr: sw_reset, bl: blank, al: alarm};

    out_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [1:0] e_rz  = 2'd0;
    logic [1:0] e_fld = 2'd0;
    logic [5:0] e_bl  = 6'd0;
    logic       e_al  = 1'b0;
    logic       e_inc = 1'b0;
    logic       e_dec = 1'b0;
    logic [2:0] e_tb  = 3'd0;
    logic       e_ss  = 1'b0;
    logic       e_sr  = 1'b0;

    task automatic check_one();
        out_t  e;
        string tg;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            tg = tag_q.pop_front();
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tg, obs, e);
            end
        end
    endtask

    // drive one cycle of inputs and queue what the outputs must be
    // one edge later; pulse expectations apply to this step only
    task automatic step(input logic r, input logic [3:0] b,
                        input logic t, input logic d, input string tag);
        @(posedge clock);
        #1;
        check_one();
        reset      = r;
        btn_pulse  = b;
        tick_2hz   = t;
        timer_done = d;
        exp_q.push_back('{rz: e_rz, inc: e_inc, dec: e_dec, fld: e_fld,
                          tb: e_tb, ss: e_ss, sr: e_sr, bl: e_bl,
                          al: e_al});
        tag_q.push_back(tag);
        e_inc = 1'b0;
        e_dec = 1'b0;
        e_tb  = 3'd0;
        e_ss  = 1'b0;
        e_sr  = 1'b0;
    endtask

    task automatic to_all_zero();
        e_rz = 2'd0; e_fld = 2'd0; e_bl = 6'd0; e_al = 1'b0;
    endtask

    localparam logic [3:0] MODE = 4'b0001;
    localparam logic [3:0] B1   = 4'b0010;
    localparam logic [3:0] B2   = 4'b0100;
    localparam logic [3:0] B3   = 4'b1000;
    localparam logic [3:0] NONE = 4'b0000;

    initial begin
        // reset ignores every input
        to_all_zero();
        step(1, 4'hF, 1, 1, "reset_inputs_ignored");
        step(0, NONE, 0, 0, "reset_idle");

        // mode sequence
        e_rz = 2'd1; step(0, MODE, 0, 0, "mode_1");
        e_rz = 2'd2; step(0, MODE, 0, 0, "mode_2");
        e_rz = 2'd3; step(0, MODE, 0, 0, "mode_3");
        e_rz = 2'd0; step(0, MODE, 0, 0, "mode_wrap_0");
        e_rz = 2'd1; step(0, MODE, 0, 0, "mode_1_again");
        e_rz = 2'd2; step(0, MODE, 0, 0, "to_timer");
        e_rz = 2'd3; step(0, MODE, 0, 0, "to_sw");

        // stopwatch routing
        e_ss = 1'b1; step(0, B1, 0, 0, "sw_b1");
        step(0, B3, 0, 0, "sw_b3_dropped");
        e_sr = 1'b1; step(0, B2, 0, 0, "sw_b2");
        step(0, NONE, 1, 0, "sw_tick_nothing");

        // clock mode forwards nothing
        e_rz = 2'd0; step(0, MODE, 0, 0, "to_clock");
        step(0, B1, 0, 0, "clock_b1_dropped");
        step(0, B3, 1, 0, "clock_b3_dropped");

        // setup field and blink
        e_rz = 2'd1; step(0, MODE, 0, 0, "to_setup");
        e_fld = 2'd1; step(0, B3, 0, 0, "setup_field_1");
        e_bl = 6'b001100; step(0, NONE, 1, 0, "blink_minutes");
        e_inc = 1'b1; e_bl = 6'd0; step(0, B1, 0, 0, "setup_inc_unblank");
        e_bl = 6'b001100; step(0, NONE, 1, 0, "blink_again");
        e_bl = 6'd0; step(0, NONE, 1, 0, "blink_off");
        e_dec = 1'b1; step(0, B2, 1, 0, "setup_dec_beats_tick");
        e_fld = 2'd2; step(0, B3, 0, 0, "setup_field_2");
        e_bl = 6'b000011; step(0, NONE, 1, 0, "blink_seconds");
        e_fld = 2'd0; e_bl = 6'd0; step(0, B3, 0, 0, "field_wrap_0");
        e_fld = 2'd1; step(0, B3, 0, 0, "field_1_again");
        e_bl = 6'b001100; step(0, NONE, 1, 0, "blink_before_leave");

        // MODE wins over a same-cycle B1
        e_rz = 2'd2; e_bl = 6'd0; step(0, MODE | B1, 0, 0, "mode_beats_b1");
        e_rz = 2'd3; step(0, MODE, 0, 0, "leave_timer");
        e_rz = 2'd0; step(0, MODE, 0, 0, "leave_sw");
        e_rz = 2'd1; e_fld = 2'd0; step(0, MODE, 0, 0, "setup_entry_reset");
        e_bl = 6'b110000; step(0, NONE, 1, 0, "entry_blink_hours");

        // inactivity: 29 ticks, B2 restarts at tick 30, then 60 more
        e_inc = 1'b1; e_bl = 6'd0; step(0, B1, 0, 0, "idle_clear");
        for (int k = 1; k <= 29; k++) begin
            e_bl = (k % 2) ? 6'b110000 : 6'd0;
            step(0, NONE, 1, 0, "idle_first_run");
        end
        e_dec = 1'b1; e_bl = 6'd0; step(0, B2, 1, 0, "idle_restart");
        for (int k = 1; k <= 59; k++) begin
            e_bl = (k % 2) ? 6'b110000 : 6'd0;
            step(0, NONE, 1, 0, "idle_still_setup");
        end
        e_rz = 2'd0; e_bl = 6'd0; step(0, NONE, 1, 0, "idle_timeout");
        step(0, NONE, 0, 0, "after_timeout");

        // alarm from stopwatch with a same-cycle MODE
        e_rz = 2'd1; step(0, MODE, 0, 0, "a_setup");
        e_rz = 2'd2; step(0, MODE, 0, 0, "a_timer");
        e_rz = 2'd3; step(0, MODE, 0, 0, "a_sw");
        e_rz = 2'd2; e_al = 1'b1; step(0, MODE, 0, 1, "alarm_beats_mode");
        e_al = 1'b0; step(0, B1, 0, 0, "alarm_ack_consumed");
        e_tb = 3'b001; step(0, B1, 0, 0, "timer_b1");
        e_tb = 3'b010; step(0, B2, 0, 0, "timer_b2");
        e_tb = 3'b100; step(0, B3, 0, 0, "timer_b3");
        e_al = 1'b1; step(0, NONE, 0, 1, "alarm_in_timer");
        step(0, NONE, 0, 1, "alarm_held");
        e_al = 1'b0; step(0, MODE, 0, 0, "alarm_ack_mode");
        step(0, NONE, 0, 0, "timer_stays");

        // timer_done beats the inactivity timeout
        e_rz = 2'd3; step(0, MODE, 0, 0, "b_sw");
        e_rz = 2'd0; step(0, MODE, 0, 0, "b_clock");
        e_rz = 2'd1; step(0, MODE, 0, 0, "b_setup");
        for (int k = 1; k <= 59; k++) begin
            e_bl = (k % 2) ? 6'b110000 : 6'd0;
            step(0, NONE, 1, 0, "b_ticks");
        end
        e_rz = 2'd2; e_al = 1'b1; e_bl = 6'd0;
        step(0, NONE, 1, 1, "alarm_beats_timeout");
        e_al = 1'b0; step(0, B3, 0, 0, "b_ack");

        // reset with an alarm pending and field 2 selected
        e_rz = 2'd3; step(0, MODE, 0, 0, "c_sw");
        e_rz = 2'd0; step(0, MODE, 0, 0, "c_clock");
        e_rz = 2'd1; step(0, MODE, 0, 0, "c_setup");
        e_fld = 2'd1; step(0, B3, 0, 0, "c_field_1");
        e_fld = 2'd2; step(0, B3, 0, 0, "c_field_2");
        e_rz = 2'd2; e_al = 1'b1; step(0, NONE, 0, 1, "c_alarm");
        to_all_zero(); step(1, MODE, 1, 0, "reset_mid_alarm");
        step(0, NONE, 0, 0, "no_residual");
        e_rz = 2'd1; step(0, MODE, 0, 0, "post_reset_mode");

        @(posedge clock);
        #1;
        check_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
